// File: rtl/lsu_mem_stage.sv
// Load/store memory-access stage: single-outstanding request/ready handshake,
// store lane steering and load extension, with misalign/illegal/timeout faults.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3_,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [1:0]  r_cause;
    logic [31:0] r_cnt;
    logic [31:0] r_load_data;

    logic        w_go;
    logic        w_illegal;
    logic        w_misal;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    // Request decode and store lane steering, evaluated on the live inputs in IDLE.
    always_comb begin
        w_go      = start && (is_load || is_store);
        w_illegal = (is_load && is_store)
                 || (is_load && (funct3_ == 3'b011 || funct3_ == 3'b110 || funct3_ == 3'b111))
                 || (is_store && (funct3_[2] || funct3_[1:0] == 2'b11));
        w_misal   = (funct3_[1:0] == 2'b01 && addr[0])
                 || (funct3_[1:0] == 2'b10 && addr[1:0] != 2'b00);
        w_be      = 4'b1111;
        w_wdata   = '0;
        if (is_store) begin
            case (funct3_[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h0, w_byte};
            3'b101:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_next = (w_illegal || w_misal) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ready || w_timeout) w_next = S_RESP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_we        <= 1'b0;
            r_is_load   <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_cause     <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_cnt <= '0;
                        if (w_illegal) begin
                            r_cause <= 2'd2;
                        end else if (w_misal) begin
                            r_cause <= 2'd1;
                        end else begin
                            r_cause   <= 2'd0;
                            r_addr    <= {addr[31:2], 2'b00};
                            r_wdata   <= w_wdata;
                            r_be      <= w_be;
                            r_we      <= is_store;
                            r_is_load <= is_load;
                            r_funct3  <= funct3_;
                            r_off     <= addr[1:0];
                        end
                    end
                end
                S_ACCESS: begin
                    // A response in the final allowed cycle takes precedence over the timeout.
                    if (mem_ready) begin
                        if (r_is_load) r_load_data <= w_load_ext;
                    end else if (w_timeout) begin
                        r_cause <= 2'd3;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req     = (r_state == S_ACCESS);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_be      = r_be;
    assign load_data   = r_load_data;
    assign done        = (r_state == S_RESP);
    assign fault       = (r_state == S_RESP) && (r_cause != 2'd0);
    assign fault_cause = r_cause;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed plan steps followed by random
// operations checked against an arithmetic model of the load/store rules.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3_;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ld;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3_(funct3_), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .load_data(load_data), .done(done), .fault(fault), .fault_cause(fault_cause),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_cause(input bit ld, input bit st, input logic [2:0] f3,
                                           input logic [31:0] a);
        if (ld && st) return 2'd2;
        if (ld && (f3 == 3'd3 || f3 >= 3'd6)) return 2'd2;
        if (st && f3 > 3'd2) return 2'd2;
        if ((a % m_size(f3)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int unsigned m_lane(input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        n = m_size(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned n;
        longint      v;
        n = m_size(f3);
        v = longint'((64'(rd) >> (8 * m_lane(f3, a))) & ((64'd1 << (8 * n)) - 64'd1));
        if (f3 < 3'd4 && n < 4 && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        if (!st) return 4'hF;
        v = ((32'd1 << m_size(f3)) - 32'd1) << m_lane(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (m_size(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // Issues one request at the current negedge; returns at the negedge after done
    // (or one cycle after an ignored start), so the next call is the earliest restart.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int unsigned wn,
                          input bit poke);
        logic [1:0]  cause;
        int unsigned acc;
        cause = m_cause(ld, st, f3, a);
        start = 1'b1; is_load = ld; is_store = st; funct3_ = f3; addr = a; store_data = sd;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3_ = 3'($urandom); addr = $urandom; store_data = $urandom;
        if (!ld && !st) begin
            chk("ignored_busy", 32'(busy), 32'd0);
            chk("ignored_req", 32'(mem_req), 32'd0);
            chk("ignored_done", 32'(done), 32'd0);
            return;
        end
        if (cause == 2'd1 || cause == 2'd2) begin
            chk("flt_req", 32'(mem_req), 32'd0);
            chk("flt_done", 32'(done), 32'd1);
            chk("flt_fault", 32'(fault), 32'd1);
            chk("flt_cause", 32'(fault_cause), 32'(cause));
            chk("flt_ld_kept", load_data, exp_ld);
            @(negedge clk);
            chk("flt_done_pulse", 32'(done), 32'd0);
            chk("flt_busy", 32'(busy), 32'd0);
            return;
        end
        acc = (wn < TO) ? wn + 1 : TO;
        for (int unsigned k = 0; k < acc; k++) begin
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_done", 32'(done), 32'd0);
            chk("acc_addr", mem_addr, {a[31:2], 2'b00});
            chk("acc_we", 32'(mem_we), 32'(st));
            chk("acc_be", 32'(mem_be), 32'(m_be(st, f3, a)));
            if (st) chk("acc_wdata", mem_wdata, m_wdata(f3, sd));
            if (poke && k == 0) begin
                start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3_ = 3'b010;
                addr = a ^ 32'h0000_0100;
            end
            mem_ready = (k == wn);
            mem_rdata = (k == wn) ? rd : $urandom;
            @(negedge clk);
            mem_ready = 1'b0;
            start = 1'b0; is_load = 1'b0;
        end
        if (ld && wn < TO) exp_ld = m_load(f3, a, rd);
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_req", 32'(mem_req), 32'd0);
        chk("resp_fault", 32'(fault), (wn < TO) ? 32'd0 : 32'd1);
        chk("resp_cause", 32'(fault_cause), (wn < TO) ? 32'd0 : 32'd3);
        chk("resp_load_data", load_data, exp_ld);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_load_data", load_data, exp_ld);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3_ = 3'b000;
        addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        exp_ld = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        rst = 1'b0;

        // Word load, ready in the 4th (final) ACCESS cycle: response beats timeout.
        run_op(1, 0, 3'b010, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 3, 0);
        chk("lw_const", load_data, 32'hDEAD_BEEF);

        run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 0);
        chk("lb_const", load_data, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0, 0);
        chk("lbu_const", load_data, 32'h0000_0080);
        run_op(1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 1, 0);
        chk("lh_const", load_data, 32'hFFFF_80FF);
        run_op(1, 0, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 0, 0);
        chk("lhu_const", load_data, 32'h0000_7F01);

        start = 1'b1; is_store = 1'b1; funct3_ = 3'b000; addr = 32'h0000_2002;
        store_data = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; is_store = 1'b0;
        chk("sb_be_const", 32'(mem_be), 32'h4);
        chk("sb_wdata_const", mem_wdata, 32'h7878_7878);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        run_op(0, 1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 0, 0);
        run_op(0, 1, 3'b010, 32'h0000_2004, 32'h1234_5678, 32'h0, 2, 0);
        chk("st_ld_kept", load_data, 32'h0000_7F01);

        run_op(1, 0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 0, 0);
        run_op(0, 1, 3'b100, 32'h0000_2000, 32'h0, 32'h0, 0, 0);
        run_op(1, 1, 3'b010, 32'h0000_2000, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 3'b011, 32'h0000_1001, 32'h0, 32'h0, 0, 0);
        run_op(0, 0, 3'b010, 32'h0000_2000, 32'h0, 32'h0, 0, 0);

        run_op(1, 0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 99, 0);
        run_op(0, 1, 3'b000, 32'h0000_3001, 32'hAB, 32'h0, 99, 1);
        run_op(1, 0, 3'b010, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 1, 1);

        // Reset during the second ACCESS cycle abandons the request.
        start = 1'b1; is_load = 1'b1; funct3_ = 3'b010; addr = 32'h0000_4000;
        @(negedge clk);
        start = 1'b0; is_load = 1'b0;
        chk("rstmid_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("rstmid_req2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ld = '0;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_no_done", 32'(done), 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            bit          ld;
            bit          st;
            sel = $urandom_range(0, 9);
            ld  = (sel == 1) || (sel >= 2 && sel < 6);
            st  = (sel == 1) || (sel >= 6);
            run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the ALU. It takes the ALU-computed effective address (S_TYPE address, or the load address from the I_TYPE add) plus rs2 store data.
- Runs a single-outstanding request/ready handshake to data memory.
- Returns sign/zero-extended load data, or a fault, to writeback.
- Multi-cycle; the control unit stalls the pipeline while busy is high.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles waiting for mem_ready before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request pulse from control
- is_load  in  1  operation is LB/LH/LW/LBU/LHU
- is_store  in  1  operation is SB/SH/SW
- funct3_  in  3  width/sign select (RISC-V encoding)
- addr  in  32  effective address (ALU output c)
- store_data  in  32  rs2 value
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word address: {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepted/completed this cycle
- mem_rdata  in  32  read word, valid when mem_ready
- load_data  out  32  extended load result, held until next done
- done  out  1  one-cycle completion pulse
- fault  out  1  with done: operation aborted
- fault_cause  out  2  0 none, 1 misaligned, 2 illegal funct3/op, 3 timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, rst high at an edge): state IDLE; mem_req, mem_we, done, fault, busy = 0; mem_addr, mem_wdata, load_data = 0; mem_be = 0; fault_cause = 0; timeout counter = 0. Reset mid-ACCESS abandons the request: mem_req is low the cycle after the reset edge, and no done is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - start is sampled only here; start while busy is ignored.
  - start with is_load = is_store = 0 is ignored.
  - Illegal: is_load and is_store both 1; load funct3 in {011,110,111}; store funct3 > 010. Go to RESP with fault_cause = 2.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0. Go to RESP with fault_cause = 1.
  - Illegal takes priority over misaligned. Faulted operations never assert mem_req.
  - Otherwise latch operands, drive mem_* registered, and go to ACCESS.
- ACCESS:
  - mem_req = 1; mem_addr, mem_we, mem_be, mem_wdata held stable until mem_ready.
  - On mem_ready = 1, capture mem_rdata (loads) and go to RESP. Minimum latency: start at edge N, mem_req high in cycle N+1, mem_ready in N+1, done in N+2.
  - Counter increments each ACCESS cycle with mem_ready = 0. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with mem_ready still 0, go to RESP with fault_cause = 3. ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - mem_ready in that same final cycle wins over timeout.
- RESP: done = 1 for exactly one cycle; fault = (fault_cause != 0); return to IDLE. busy is low the following cycle, so the earliest next start is accepted one cycle after done.
- Store lanes, with o = addr[1:0]:
  - SB: mem_be = 4'b0001 << o; mem_wdata = {4{store_data[7:0]}}.
  - SH: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{store_data[15:0]}}.
  - SW: mem_be = 4'b1111; mem_wdata = store_data.
- Loads: mem_be = 4'b1111, mem_we = 0. Select the byte at lane o, or the halfword at addr[1].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: full word.
- load_data updates only on a successful load completion; stores and faults leave it unchanged.
- mem_ready outside ACCESS is ignored.

Test Plan:
- Word load: addr=0x0000_1008, LW, memory returns 0xDEADBEEF with mem_ready 3 cycles after mem_req -> mem_addr=0x1008, mem_be=1111, done pulses once, load_data=0xDEADBEEF, fault=0.
- Byte/half extension: mem_rdata=0x80FF7F01. LB@off3 -> 0xFFFFFF80; LBU@off3 -> 0x00000080; LH@off2 -> 0xFFFF80FF; LHU@off0 -> 0x00007F01.
- Stores: store_data=0x12345678. SB@0x...2 -> be=0100, wdata=0x78787878; SH@0x...2 -> be=1100, wdata=0x56785678; SW -> be=1111, mem_we=1; load_data unchanged.
- Faults: LW@0x...1 -> done+fault, cause=1, mem_req never high. Store funct3=100 -> cause=2. is_load=is_store=1 -> cause=2.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then done with cause=3. Variant with mem_ready in the 4th cycle -> normal completion, no fault.
- Reset/back-to-back: start pulsed again during ACCESS -> ignored. rst asserted in 2nd ACCESS cycle -> mem_req low next cycle, no done, busy=0. Zero-wait mem_ready -> done exactly 2 cycles after start, next start accepted the cycle after done.
